// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout has fixed priority, the CPU gets the free cycles via req/ack.
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN.
module vram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        disp_req,
   input  logic [15:0] disp_addr,
   output logic [15:0] disp_data,
   output logic        disp_stall,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_be,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic {IDLE, ISSUED} state_t;

   state_t      state_q, state_d;
   logic        is_read_q, is_read_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] hold_q, hold_d;
   logic        last_disp_q, last_disp_d;
   logic        gnt_cpu;
   logic        force_gnt;

`ifdef VRAM_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          disp_stall_q, disp_stall_d;

   always_comb begin
      force_gnt    = (wait_cnt_q == CW'(STARVE_LIMIT));
      wait_cnt_d   = wait_cnt_q;
      if (gnt_cpu || !cpu_req)
         wait_cnt_d = '0;
      else if (state_q == IDLE)
         wait_cnt_d = wait_cnt_q + CW'(1);
      disp_stall_d = disp_req && gnt_cpu;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q   <= '0;
         disp_stall_q <= 1'b0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         disp_stall_q <= disp_stall_d;
      end
   end

   assign disp_stall = disp_stall_q;
`else
   assign force_gnt  = 1'b0;
   assign disp_stall = 1'b0;
`endif

   always_comb begin
      // Grant is masked during reset so no write can be strobed while rst is held.
      gnt_cpu = !rst && (state_q == IDLE) && cpu_req && (!disp_req || force_gnt);

      mem_addr  = disp_addr;
      mem_we    = 1'b0;
      mem_be    = 2'b11;
      mem_wdata = '0;
      if (gnt_cpu) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_be    = cpu_be;
         mem_wdata = cpu_wdata;
      end

      state_d   = state_q;
      is_read_d = is_read_q;
      case (state_q)
         IDLE: begin
            if (gnt_cpu) begin
               state_d   = ISSUED;
               is_read_d = !cpu_we;
            end
         end
         ISSUED:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cpu_ack   = (state_q == ISSUED);
      rdata_d   = rdata_q;
      cpu_rdata = rdata_q;
      if (cpu_ack && is_read_q) begin
         rdata_d   = mem_rdata;
         cpu_rdata = mem_rdata;
      end

      last_disp_d = disp_req && !gnt_cpu;
      hold_d      = last_disp_q ? mem_rdata : hold_q;
      disp_data   = hold_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         is_read_q   <= 1'b0;
         rdata_q     <= '0;
         hold_q      <= '0;
         last_disp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_read_q   <= is_read_d;
         rdata_q     <= rdata_d;
         hold_q      <= hold_d;
         last_disp_q <= last_disp_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a cycle driver predicts responses from the arbitration rules,
// a negedge monitor pops and compares them. Define VRAM_STARVE_GUARD_EN to exercise the guard.
module tb_vram_arbiter;

   localparam int unsigned LIMIT = 8;
`ifdef VRAM_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        disp_req;
   logic [15:0] disp_addr;
   logic [15:0] disp_data;
   logic        disp_stall;
   logic        cpu_req;
   logic        cpu_we;
   logic [1:0]  cpu_be;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_stall(disp_stall),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // VRAM macro: synchronous read, byte-lane writes
   logic [15:0] vram [0:65535];
   always @(posedge clk) begin
      mem_rdata <= vram[mem_addr];
      if (mem_we) begin
         if (mem_be[0]) vram[mem_addr][7:0]  <= mem_wdata[7:0];
         if (mem_be[1]) vram[mem_addr][15:8] <= mem_wdata[15:8];
      end
   end

   typedef struct { int cyc; bit rd; logic [15:0] data; } ack_t;
   typedef struct { logic [15:0] addr; logic [1:0] be; logic [15:0] data; } wr_t;
   typedef struct { logic [15:0] data; bit stall; } dsp_t;

   ack_t aq[$];
   wr_t  wq[$];
   dsp_t dq[$];

   int errors = 0;
   int checks = 0;

   // Reference memory: preload is data == address, overridden by writes
   logic [15:0] refw [int];

   function automatic logic [15:0] refm(input logic [15:0] a);
      if (refw.exists(int'(a))) return refw[int'(a)];
      return a;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Driver-side model state
   int          phase = 0;       // 0 no request, 1 waiting, 2 ack cycle
   int          waited = 0;
   bit          p_we;
   logic [1:0]  p_be;
   logic [15:0] p_addr, p_wdata;
   logic [15:0] dh = '0;         // last display value actually fetched

   task automatic cpu_start(input bit we, input logic [1:0] be, input logic [15:0] a,
                            input logic [15:0] wd);
      cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
      p_we = we; p_be = be; p_addr = a; p_wdata = wd;
      phase = 1; waited = 0;
   endtask

   task automatic drive_cycle(input bit dr, input logic [15:0] da);
      bit          gnt;
      logic [15:0] v;
      if (phase == 0) cpu_req = 1'b0;
      disp_req  = dr;
      disp_addr = da;
      gnt = (phase == 1) && (!dr || (GUARD && waited == int'(LIMIT)));
      if (phase == 1 && !gnt) waited++;
      if (dr) begin
         if (gnt) dq.push_back('{dh, 1'b1});
         else begin
            v = refm(da);
            dq.push_back('{v, 1'b0});
            dh = v;
         end
      end
      if (gnt) begin
         v = refm(p_addr);
         if (p_we) begin
            wq.push_back('{p_addr, p_be, p_wdata});
            if (p_be[0]) v[7:0]  = p_wdata[7:0];
            if (p_be[1]) v[15:8] = p_wdata[15:8];
            refw[int'(p_addr)] = v;
         end
         aq.push_back('{cyc + 1, !p_we, v});
         phase = 2;
      end else if (phase == 2) phase = 0;
      #1;
      chk("mem_addr", mem_addr, gnt ? p_addr : da);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   bit          prev_dr = 1'b0;
   logic [15:0] mon_hold = '0;
   logic [15:0] mon_rd = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_dr  = 1'b0;
         mon_hold = '0;
         mon_rd   = '0;
      end else begin
         if (cpu_ack) begin
            if (aq.size() == 0) chk("unexpected_ack", cpu_ack, 1'b0);
            else begin
               ack_t e;
               e = aq.pop_front();
               chk("ack_cycle", cyc, e.cyc);
               if (e.rd) begin
                  chk("cpu_rdata", cpu_rdata, e.data);
                  mon_rd = e.data;
               end
            end
         end else chk("cpu_rdata_hold", cpu_rdata, mon_rd);

         if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_mem_we", mem_we, 1'b0);
            else begin
               wr_t w;
               w = wq.pop_front();
               chk("mem_we_addr", mem_addr, w.addr);
               chk("mem_we_be", mem_be, w.be);
               chk("mem_wdata", mem_wdata, w.data);
            end
         end

         if (prev_dr) begin
            if (dq.size() == 0) chk("disp_unpredicted", disp_data, mon_hold ^ 16'hFFFF);
            else begin
               dsp_t d;
               d = dq.pop_front();
               chk("disp_data", disp_data, d.data);
               chk("disp_stall", disp_stall, d.stall);
               mon_hold = d.data;
            end
         end else begin
            chk("disp_hold", disp_data, mon_hold);
            chk("disp_stall_idle", disp_stall, 1'b0);
         end
         prev_dr = disp_req;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) vram[i] = 16'(i);
      rst = 1'b1; disp_req = 1'b0; disp_addr = 16'h0033;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
      chk("rst_disp_data", disp_data, 16'h0000);
      chk("rst_disp_stall", disp_stall, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0033);
      rst = 1'b0;

      // Byte-lane write then immediate back-to-back read
      cpu_start(1'b1, 2'b01, 16'h0100, 16'hA5C3);
      drive_cycle(1'b0, 16'h0000);
      drive_cycle(1'b0, 16'h0000);
      cpu_start(1'b0, 2'b11, 16'h0100, 16'h0000);
      drive_cycle(1'b0, 16'h0000);
      drive_cycle(1'b0, 16'h0000);
      drive_cycle(1'b0, 16'h0000);

      // Continuous scanout with a CPU read pending throughout
      cpu_start(1'b0, 2'b11, 16'h0200, 16'h0000);
      for (int i = 0; i < 240; i++) drive_cycle(1'b1, 16'(i));
      repeat (3) drive_cycle(1'b0, 16'h0000);

      // Display request rising in the ack cycle of a read
      cpu_start(1'b0, 2'b11, 16'h0005, 16'h0000);
      drive_cycle(1'b0, 16'h0000);
      drive_cycle(1'b1, 16'h0100);
      drive_cycle(1'b0, 16'h0000);
      drive_cycle(1'b0, 16'h0000);

      // Reset during the ack cycle of a write
      cpu_start(1'b1, 2'b10, 16'h0300, 16'hBEEF);
      drive_cycle(1'b0, 16'h0000);
      rst = 1'b1;
      #1;
      chk("reset_kills_ack", cpu_ack, 1'b0);
      chk("reset_mem_we", mem_we, 1'b0);
      aq.delete();
      phase = 0; cpu_req = 1'b0; dh = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("vram_after_reset", vram[16'h0300], refm(16'h0300));
      cpu_start(1'b0, 2'b11, 16'h0300, 16'h0000);
      repeat (3) drive_cycle(1'b0, 16'h0000);

      // Randomised traffic over a small shared address window
      for (int n = 0; n < 400; n++) begin
         if (phase == 0 && $urandom_range(0, 2) == 0)
            cpu_start(1'($urandom), 2'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
         drive_cycle(1'($urandom), 16'($urandom_range(0, 15)));
      end
      repeat (4) drive_cycle(1'b0, 16'h0000);

      chk("acks_outstanding", aq.size(), 0);
      chk("writes_outstanding", wq.size(), 0);
      chk("disp_outstanding", dq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
